if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 94 +++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC, one outstanding imem request, redirect drain.
// Optional HALT-opcode detection is enabled with `define IF_HALT_DETECT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic        valid
);

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;
  localparam logic [5:0] HALT_OP = 6'b010001;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] tgt;
  logic        accept;

  assign tgt = redirect_pc & 32'hFFFF_FFFC;

  // Request depends on this cycle's stall, so it cannot be registered.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = !valid || !stall;
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign accept    = (state == FETCH) && imem_req && imem_ack && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      inst       <= 32'h0;
      pc_out     <= 32'h0;
      valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            pc    <= tgt;
            valid <= 1'b0;
            // Request already on the bus must complete before the new target is fetched.
            if (imem_req && !imem_ack) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (accept) begin
            inst   <= imem_rdata;
            pc_out <= pc;
            valid  <= 1'b1;
            pc     <= pc + 32'd4;
`ifdef IF_HALT_DETECT_EN
            if (imem_rdata[31:26] == HALT_OP) state <= HALTED;
`endif
          end else if (valid && !stall) begin
            valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (redirect) pc <= tgt;
          if (imem_ack) state <= FETCH;
        end
`ifdef IF_HALT_DETECT_EN
        HALTED: begin
          if (valid && !stall) valid <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a cycle-level reference model.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit          m_started, m_draining, m_halted, m_valid;
  logic [31:0] m_pc, m_drain_addr, m_inst, m_pc_out;
  logic [31:0] saved_pc;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst),
    .pc_out(pc_out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_draining = 0; m_halted = 0; m_valid = 0;
    m_pc = RESET_PC; m_drain_addr = RESET_PC; m_inst = 0; m_pc_out = 0;
  endtask

  // One cycle: drive inputs, check request side, clock, advance model, check outputs.
  task automatic step(input bit ack, input bit stl, input bit rd,
                      input logic [31:0] rpc, input logic [31:0] data);
    bit          ereq;
    logic [31:0] eaddr;
    imem_ack = ack; stall = stl; redirect = rd; redirect_pc = rpc; imem_rdata = data;
    #2;
    ereq  = m_started && !m_halted && (m_draining || !m_valid || !stl);
    eaddr = m_draining ? m_drain_addr : m_pc;
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    chk("imem_addr", imem_addr, eaddr);
    @(posedge clk);
    if (!m_started) m_started = 1;
    else if (m_halted) begin
      if (m_valid && !stl) m_valid = 0;
    end else if (m_draining) begin
      if (rd) m_pc = {rpc[31:2], 2'b00};
      if (ack) m_draining = 0;
    end else if (rd) begin
      if (ereq && !ack) begin m_draining = 1; m_drain_addr = m_pc; end
      m_pc = {rpc[31:2], 2'b00};
      m_valid = 0;
    end else if (ereq && ack) begin
      m_inst = data; m_pc_out = m_pc; m_valid = 1; m_pc = m_pc + 4;
`ifdef IF_HALT_DETECT_EN
      if (data[31:26] == 6'b010001) m_halted = 1;
`endif
    end else if (m_valid && !stl) m_valid = 0;
    #1;
    chk("inst", inst, m_inst);
    chk("pc_out", pc_out, m_pc_out);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
  endtask

  function automatic logic [31:0] rword();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'b000000;
    return w;
  endfunction

  initial begin
    reset = 1'b0; imem_ack = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_rdata = 0;
    model_reset();
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // sequential fetch, ack tied high
    step(1, 0, 0, 0, rword());
    step(1, 0, 0, 0, rword());
    chk("seq_pc0", pc_out, 32'h0);
    step(1, 0, 0, 0, rword());
    chk("seq_pc4", pc_out, 32'h4);
    chk("seq_addr8", imem_addr, 32'h8);
    step(1, 0, 0, 0, rword());
    step(1, 0, 0, 0, rword());

    // stall for three cycles, then resume at pc_out+4
    saved_pc = pc_out;
    repeat (3) step(1, 1, 0, 0, rword());
    chk("stall_pc_hold", pc_out, saved_pc);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    step(1, 0, 0, 0, rword());
    chk("stall_resume", pc_out, saved_pc + 4);

    // ack withheld, redirect -> drain old request, then fetch 0x100
    saved_pc = imem_addr;
    step(0, 0, 0, 0, rword());
    step(0, 0, 0, 0, rword());
    step(0, 0, 1, 32'h100, rword());
    chk("drain_addr", imem_addr, saved_pc);
    step(0, 0, 0, 0, rword());
    step(1, 0, 0, 0, rword());
    chk("drain_valid0", {31'b0, valid}, 32'h0);
    chk("drain_next", imem_addr, 32'h100);
    step(1, 0, 0, 0, rword());
    chk("drain_pc100", pc_out, 32'h100);

    // redirect coincident with ack; low bits forced off
    step(1, 0, 1, 32'h203, rword());
    chk("rd_valid0", {31'b0, valid}, 32'h0);
    chk("rd_addr200", imem_addr, 32'h200);

    // redirect under stall still clears valid
    step(1, 0, 0, 0, rword());
    step(1, 1, 1, 32'hFFFF_FFFC, rword());
    chk("rd_stall_valid", {31'b0, valid}, 32'h0);

    // PC wrap
    step(1, 0, 0, 0, rword());
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // HALT opcode at 0xC
    step(1, 0, 1, 32'hC, rword());
    step(1, 0, 0, 0, 32'h4400_0000);
    chk("halt_inst", inst, 32'h4400_0000);
    chk("halt_pc", pc_out, 32'hC);
`ifdef IF_HALT_DETECT_EN
    step(1, 0, 0, 0, rword());
    step(1, 0, 1, 32'h40, rword());
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    chk("halt_pc_keep", pc_out, 32'hC);
    step(1, 0, 0, 0, rword());
    reset = 1'b0; model_reset(); #1; reset = 1'b1;
    step(1, 0, 0, 0, rword());
`else
    chk("nohalt_addr", imem_addr, 32'h10);
    step(1, 0, 0, 0, rword());
    chk("nohalt_pc10", pc_out, 32'h10);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0,
           $urandom, rword());

    // asynchronous reset mid-run, between edges
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_valid", {31'b0, valid}, 32'h0);
    chk("arst_inst", inst, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) step(1, 0, 0, 0, rword());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
